// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard unit: M/W/MDU forwarding, load-use and MDU scoreboard stalls,
// branch/jump flush, data-memory wait stall, and outstanding MDU op tracking.
module hazard_scoreboard_unit #(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned NUM_REGS    = 32,
    parameter int unsigned MDU_MAX_OUT = 2,
    parameter int unsigned CNT_W       = $clog2(MDU_MAX_OUT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs1_D,
    input  logic [REG_AW-1:0] rs2_D,
    input  logic [REG_AW-1:0] rd_D,
    input  logic [REG_AW-1:0] rs1_E,
    input  logic [REG_AW-1:0] rs2_E,
    input  logic [REG_AW-1:0] rd_E,
    input  logic [1:0]        wb_sel_E,
    input  logic              mdu_issue_E,
    input  logic              pc_src_E,
    input  logic              jump_E,
    input  logic [REG_AW-1:0] rd_M,
    input  logic [REG_AW-1:0] rd_W,
    input  logic              reg_write_M,
    input  logic              reg_write_W,
    input  logic              dmem_stall_M,
    input  logic              mdu_done,
    input  logic [REG_AW-1:0] mdu_rd,
    output logic [1:0]        forward_a_E,
    output logic [1:0]        forward_b_E,
    output logic              stall_F,
    output logic              stall_D,
    output logic              stall_E,
    output logic              stall_M,
    output logic              flush_D,
    output logic              flush_E,
    output logic              flush_M,
    output logic              flush_W,
    output logic [CNT_W-1:0]  mdu_outstanding,
    output logic              sb_err
);

    logic [NUM_REGS-1:0] pending_q, pending_d, pend_eff;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                err_q, err_d;

    logic lw_stall, mdu_e_stall, sb_stall, full_stall, redirect, accept, dec;

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != '0) begin
            if (reg_write_M && rd_M == rs) begin
                sel = 2'b10;
            end else if (reg_write_W && rd_W == rs) begin
                sel = 2'b01;
            end else if (mdu_done && mdu_rd == rs) begin
                sel = 2'b11;
            end
        end
        return sel;
    endfunction

    function automatic logic busy(input logic [REG_AW-1:0] a, input logic [NUM_REGS-1:0] v);
        logic hit;
        hit = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (a == REG_AW'(r)) hit = v[r];
        end
        return hit;
    endfunction

    // Write-through regfile: a register completing this cycle is already free.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            pend_eff[r] = pending_q[r] && !(mdu_done && mdu_rd == REG_AW'(r));
        end
    end

    always_comb begin
        forward_a_E = fwd_sel(rs1_E);
        forward_b_E = fwd_sel(rs2_E);
    end

    always_comb begin
        lw_stall    = (wb_sel_E == 2'b01) && (rd_E != '0) &&
                      ((rs1_D == rd_E) || (rs2_D == rd_E));
        mdu_e_stall = mdu_issue_E && (rd_E != '0) &&
                      ((rs1_D == rd_E) || (rs2_D == rd_E) || (rd_D == rd_E));
        sb_stall    = busy(rs1_D, pend_eff) || busy(rs2_D, pend_eff) || busy(rd_D, pend_eff);
        full_stall  = mdu_issue_E && (count_q == CNT_W'(MDU_MAX_OUT)) && !mdu_done;
        redirect    = pc_src_E || jump_E;
    end

    // Memory wait dominates so a pending redirect is re-evaluated once M drains.
    always_comb begin
        stall_F = 1'b0;
        stall_D = 1'b0;
        stall_E = 1'b0;
        stall_M = 1'b0;
        flush_D = 1'b0;
        flush_E = 1'b0;
        flush_M = 1'b0;
        flush_W = 1'b0;
        if (dmem_stall_M) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            stall_E = 1'b1;
            stall_M = 1'b1;
            flush_W = 1'b1;
        end else if (full_stall) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            stall_E = 1'b1;
            flush_M = 1'b1;
        end else if (redirect) begin
            flush_D = 1'b1;
            flush_E = 1'b1;
        end else if (lw_stall || mdu_e_stall || sb_stall) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            flush_E = 1'b1;
        end
    end

    always_comb begin
        accept    = mdu_issue_E && !stall_E && (rd_E != '0);
        dec       = mdu_done && (count_q != '0);
        pending_d = pending_q;
        // Clear before set so a same-register issue in the completion cycle wins.
        for (int r = 0; r < NUM_REGS; r++) begin
            if (mdu_done && mdu_rd == REG_AW'(r)) pending_d[r] = 1'b0;
            if (accept && rd_E == REG_AW'(r)) pending_d[r] = 1'b1;
        end
        count_d = count_q;
        if (accept && !dec) begin
            count_d = count_q + CNT_W'(1);
        end else if (!accept && dec) begin
            count_d = count_q - CNT_W'(1);
        end
        err_d = err_q || (mdu_done && (count_q == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

    assign mdu_outstanding = count_q;
    assign sb_err          = err_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit with default parameters.
module tb_hazard_scoreboard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1_D, rs2_D, rd_D, rs1_E, rs2_E, rd_E, rd_M, rd_W, mdu_rd;
    logic [1:0] wb_sel_E;
    logic       mdu_issue_E, pc_src_E, jump_E, reg_write_M, reg_write_W;
    logic       dmem_stall_M, mdu_done;
    logic [1:0] forward_a_E, forward_b_E;
    logic       stall_F, stall_D, stall_E, stall_M;
    logic       flush_D, flush_E, flush_M, flush_W;
    logic [1:0] mdu_outstanding;
    logic       sb_err;

    int total = 0;
    int bad   = 0;

    hazard_scoreboard_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rs1_D           (rs1_D),
        .rs2_D           (rs2_D),
        .rd_D            (rd_D),
        .rs1_E           (rs1_E),
        .rs2_E           (rs2_E),
        .rd_E            (rd_E),
        .wb_sel_E        (wb_sel_E),
        .mdu_issue_E     (mdu_issue_E),
        .pc_src_E        (pc_src_E),
        .jump_E          (jump_E),
        .rd_M            (rd_M),
        .rd_W            (rd_W),
        .reg_write_M     (reg_write_M),
        .reg_write_W     (reg_write_W),
        .dmem_stall_M    (dmem_stall_M),
        .mdu_done        (mdu_done),
        .mdu_rd          (mdu_rd),
        .forward_a_E     (forward_a_E),
        .forward_b_E     (forward_b_E),
        .stall_F         (stall_F),
        .stall_D         (stall_D),
        .stall_E         (stall_E),
        .stall_M         (stall_M),
        .flush_D         (flush_D),
        .flush_E         (flush_E),
        .flush_M         (flush_M),
        .flush_W         (flush_W),
        .mdu_outstanding (mdu_outstanding),
        .sb_err          (sb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rs1_D = 0; rs2_D = 0; rd_D = 0; rs1_E = 0; rs2_E = 0; rd_E = 0;
        rd_M = 0; rd_W = 0; mdu_rd = 0; wb_sel_E = 2'b00;
        mdu_issue_E = 0; pc_src_E = 0; jump_E = 0; reg_write_M = 0; reg_write_W = 0;
        dmem_stall_M = 0; mdu_done = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // {stall_F,stall_D,stall_E,stall_M,flush_D,flush_E,flush_M,flush_W}
    function automatic logic [7:0] ctl();
        return {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_M, flush_W};
    endfunction

    initial begin
        idle();
        rst_n = 1'b0;
        #3;
        chk("reset_count", 32'(mdu_outstanding), 0);
        chk("reset_err", 32'(sb_err), 0);
        chk("reset_ctl", 32'(ctl()), 32'h00);
        chk("reset_fwd", 32'({forward_a_E, forward_b_E}), 0);
        #4 rst_n = 1'b1;
        tick();

        // Load-use: lw x5 in E, add x6,x5,x1 in D
        wb_sel_E = 2'b01; rd_E = 5; rs1_D = 5; rs2_D = 1; rd_D = 6;
        #1 chk("lw_stall_ctl", 32'(ctl()), 32'b1100_0100);
        tick();
        idle(); rd_M = 5; reg_write_M = 1; rs1_D = 5; rs2_D = 1; rd_D = 6;
        #1 chk("lw_bubble_ctl", 32'(ctl()), 32'h00);
        tick();
        idle(); rs1_E = 5; rs2_E = 1; rd_W = 5; reg_write_W = 1;
        #1 chk("lw_fwd_a_W", 32'(forward_a_E), 32'b01);
        chk("lw_fwd_b_none", 32'(forward_b_E), 32'b00);
        rd_M = 5; reg_write_M = 1;
        #1 chk("fwd_M_priority", 32'(forward_a_E), 32'b10);
        rs1_E = 0; rd_M = 0; rd_W = 0;
        #1 chk("fwd_x0_never", 32'(forward_a_E), 32'b00);
        tick();

        // div x7 issued while D writes x7 (WAW): D stalls, E still issues
        idle(); mdu_issue_E = 1; rd_E = 7; rd_D = 7;
        #1 chk("mdu_e_waw_ctl", 32'(ctl()), 32'b1100_0100);
        tick();
        idle();
        chk("div_count1", 32'(mdu_outstanding), 1);
        rs1_D = 7; rs2_D = 2; rd_D = 8;
        for (int i = 0; i < 20; i++) begin
            #1 chk("sb_wait_stall_D", 32'(stall_D), 1);
            tick();
        end
        mdu_done = 1; mdu_rd = 7; rs1_E = 7;
        #1 chk("sb_done_stall_D", 32'(stall_D), 0);
        chk("fwd_mdu", 32'(forward_a_E), 32'b11);
        tick();
        idle();
        chk("div_count0", 32'(mdu_outstanding), 0);

        // Fill to MDU_MAX_OUT, third op waits for a completion
        mdu_issue_E = 1; rd_E = 9;
        tick();
        rd_E = 10;
        tick();
        chk("full_count2", 32'(mdu_outstanding), 2);
        rd_E = 11;
        for (int i = 0; i < 2; i++) begin
            #1 chk("full_ctl", 32'(ctl()), 32'b1110_0010);
            tick();
        end
        chk("full_count_held", 32'(mdu_outstanding), 2);
        mdu_done = 1; mdu_rd = 9;
        #1 chk("full_release_ctl", 32'(ctl()), 32'h00);
        tick();
        idle();
        chk("full_count_swap", 32'(mdu_outstanding), 2);
        rs1_D = 9;
        #1 chk("x9_free", 32'(stall_D), 0);

        // Taken branch overrides scoreboard stall of x11
        rs1_D = 11; pc_src_E = 1;
        #1 chk("redirect_ctl", 32'(ctl()), 32'b0000_1100);
        tick();
        pc_src_E = 0;
        chk("redirect_count", 32'(mdu_outstanding), 2);
        #1 chk("x11_still_pending", 32'(stall_D), 1);
        rs1_D = 0; rd_D = 10;
        #1 chk("x10_waw_pending", 32'(stall_D), 1);
        idle(); mdu_done = 1; mdu_rd = 10;
        tick();
        mdu_rd = 11;
        tick();
        idle();
        chk("drain_count0", 32'(mdu_outstanding), 0);

        // Memory wait holds a jump for 3 cycles
        dmem_stall_M = 1; jump_E = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("dmem_ctl", 32'(ctl()), 32'b1111_0001);
            tick();
        end
        dmem_stall_M = 0;
        #1 chk("jump_after_dmem", 32'(ctl()), 32'b0000_1100);
        tick();

        // Spurious completion, then async reset mid-flight
        idle(); mdu_done = 1; mdu_rd = 3;
        tick();
        idle();
        chk("err_set", 32'(sb_err), 1);
        chk("err_count0", 32'(mdu_outstanding), 0);
        tick();
        chk("err_sticky", 32'(sb_err), 1);
        mdu_issue_E = 1; rd_E = 12;
        tick();
        idle();
        chk("pre_reset_count", 32'(mdu_outstanding), 1);
        rs1_D = 12;
        #1 rst_n = 1'b0;
        #1 chk("async_rst_count", 32'(mdu_outstanding), 0);
        chk("async_rst_pending", 32'(stall_D), 0);
        chk("async_rst_err", 32'(sb_err), 0);
        #1 rst_n = 1'b1;
        idle(); mdu_done = 1; mdu_rd = 12;
        tick();
        idle();
        chk("stale_done_err", 32'(sb_err), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
